// File: rtl/branch_predictor_if.sv
// Branch predictor bus interface.
// Bundles the fetch-side lookup, the EX-side resolution inputs and the
// predictor outputs (prediction, mispredict/redirect, statistics counters).
//   master : pipeline side; drives if_pc and the ex_* resolution fields.
//   slave  : predictor side; drives pred_*, mispredict, redirect_pc, counters.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;

  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     br_count;
  logic [31:0]     mis_count;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mis_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_count, mis_count
  );
endinterface

// File: rtl/branch_predictor.sv
// IF-stage direction/target predictor with EX-stage training.
// A direct-mapped table of {valid, tag, 2-bit counter, target} entries is
// looked up combinationally with the fetch PC; the EX stage reports the
// resolved outcome, which trains the table, raises mispredict and supplies
// the corrected next PC.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high; clears table and counters
//   bp    : branch_predictor_if.slave (lookup, resolve, redirect, counters)
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  logic                valid_tab [ENTRIES];
  logic [TAG_BITS-1:0] tag_tab   [ENTRIES];
  logic [1:0]          ctr_tab   [ENTRIES];
  logic [XLEN-1:0]     tgt_tab   [ENTRIES];

  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                lookup_hit;
  logic                pred_taken;
  logic                upd;
  logic                train_hit;
  logic                dir_wrong;
  logic                tgt_wrong;
  logic                mispredict;

  assign if_idx = bp.if_pc[IDX_BITS+1:2];
  assign if_tag = bp.if_pc[TAG_HI:TAG_LO];
  assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bp.ex_pc[TAG_HI:TAG_LO];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same entry is seen by fetch one cycle later.
  assign lookup_hit     = valid_tab[if_idx] && (tag_tab[if_idx] == if_tag);
  assign pred_taken     = !reset && lookup_hit && ctr_tab[if_idx][1];
  assign bp.pred_taken  = pred_taken;
  assign bp.pred_target = pred_taken ? tgt_tab[if_idx] : bp.if_pc + XLEN'(4);

  // Only live conditional branches resolve; reset suppresses both training
  // and redirects.
  assign upd       = !reset && bp.ex_valid && bp.ex_is_branch;
  assign dir_wrong = bp.ex_taken != bp.ex_pred_taken;
  assign tgt_wrong = bp.ex_taken && bp.ex_pred_taken &&
                     (bp.ex_target != bp.ex_pred_target);
  assign mispredict     = upd && (dir_wrong || tgt_wrong);
  assign bp.mispredict  = mispredict;
  assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + XLEN'(4);

  assign train_hit = valid_tab[ex_idx] && (tag_tab[ex_idx] == ex_tag);

  assign bp.br_count  = br_cnt;
  assign bp.mis_count = mis_cnt;

  // Table training and statistics. A tag hit nudges the saturating counter
  // toward the outcome; a taken miss evicts whatever lived at that index and
  // starts the new branch as weakly taken. Not-taken misses leave the table
  // alone so a never-taken branch cannot evict a useful entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tab[i] <= 1'b0;
        tag_tab[i]   <= '0;
        ctr_tab[i]   <= 2'b01;
        tgt_tab[i]   <= '0;
      end
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (upd) begin
        br_cnt <= br_cnt + 32'd1;
        if (train_hit) begin
          if (bp.ex_taken) begin
            if (ctr_tab[ex_idx] != 2'b11) begin
              ctr_tab[ex_idx] <= ctr_tab[ex_idx] + 2'd1;
            end
            tgt_tab[ex_idx] <= bp.ex_target;
          end else if (ctr_tab[ex_idx] != 2'b00) begin
            ctr_tab[ex_idx] <= ctr_tab[ex_idx] - 2'd1;
          end
        end else if (bp.ex_taken) begin
          valid_tab[ex_idx] <= 1'b1;
          tag_tab[ex_idx]   <= ex_tag;
          ctr_tab[ex_idx]   <= 2'b10;
          tgt_tab[ex_idx]   <= bp.ex_target;
        end
      end
      if (mispredict) begin
        mis_cnt <= mis_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table for the documented
// scenarios followed by randomized traffic against a behavioural model.
module tb_branch_predictor;
  logic clk;
  logic reset;

  branch_predictor_if #(.XLEN(32)) bp_bus ();

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        exp_pred_taken;
    logic [31:0] exp_pred_target;
    logic        exp_mispredict;
    logic [31:0] exp_redirect;
    logic [31:0] exp_br;
    logic [31:0] exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst, input logic [31:0] if_pc,
                              input logic ev, input logic eb, input logic [31:0] epc,
                              input logic et, input logic [31:0] etgt,
                              input logic ept, input logic [31:0] eptgt,
                              input logic xpt, input logic [31:0] xptgt,
                              input logic xmis, input logic [31:0] xred,
                              input logic [31:0] xbr, input logic [31:0] xmc);
    vec_t v;
    v.name = name; v.rst = rst; v.if_pc = if_pc;
    v.ex_valid = ev; v.ex_is_branch = eb; v.ex_pc = epc;
    v.ex_taken = et; v.ex_target = etgt;
    v.ex_pred_taken = ept; v.ex_pred_target = eptgt;
    v.exp_pred_taken = xpt; v.exp_pred_target = xptgt;
    v.exp_mispredict = xmis; v.exp_redirect = xred;
    v.exp_br = xbr; v.exp_mis = xmc;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic [31:0] if_pc,
                                input logic ev, input logic eb, input logic [31:0] epc,
                                input logic et, input logic [31:0] etgt,
                                input logic ept, input logic [31:0] eptgt);
    @(negedge clk);
    reset                 = rst;
    bp_bus.if_pc          = if_pc;
    bp_bus.ex_valid       = ev;
    bp_bus.ex_is_branch   = eb;
    bp_bus.ex_pc          = epc;
    bp_bus.ex_taken       = et;
    bp_bus.ex_target      = etgt;
    bp_bus.ex_pred_taken  = ept;
    bp_bus.ex_pred_target = eptgt;
    #1;
  endtask

  // Behavioural model: one record per table slot, counter kept as an integer
  // strength 0..3 where 2 and above means "predict taken".
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int          m_ctr   [64];
  logic [31:0] m_tgt   [64];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 32'h0;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, input logic rst,
                               output logic taken, output logic [31:0] target);
    int s;
    s = slot_of(pc);
    taken  = !rst && m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
    target = taken ? m_tgt[s] : pc + 32'd4;
  endtask

  function automatic logic model_mispredict(input logic rst, input logic ev, input logic eb,
                                            input logic et, input logic [31:0] etgt,
                                            input logic ept, input logic [31:0] eptgt);
    if (rst || !ev || !eb) return 1'b0;
    if (et != ept) return 1'b1;
    return et && (etgt != eptgt);
  endfunction

  task automatic model_train(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    int s;
    s = slot_of(pc);
    if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
      m_ctr[s] = et ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                    : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
      if (et) m_tgt[s] = etgt;
    end else if (et) begin
      m_valid[s] = 1'b1; m_tag[s] = tag_of(pc); m_ctr[s] = 2; m_tgt[s] = etgt;
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
    if ($urandom_range(0, 3) == 0) pc = pc | 32'h0001_0000;
    return pc;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bp_bus.if_pc = 32'h0; bp_bus.ex_valid = 1'b0; bp_bus.ex_is_branch = 1'b0;
    bp_bus.ex_pc = 32'h0; bp_bus.ex_taken = 1'b0; bp_bus.ex_target = 32'h0;
    bp_bus.ex_pred_taken = 1'b0; bp_bus.ex_pred_target = 32'h0;

    //           name         rst if_pc         ev eb ex_pc         et ex_tgt        ept ept_tgt      xpt xpt_tgt       xmis xred          br mis
    vecs.push_back(mk("rst_upd",   1, 32'h100,      1, 1, 32'h100,      1, 32'h80,       0, 32'h104,     0, 32'h104,      0, 32'h0,        0, 0));
    vecs.push_back(mk("rst_idle",  1, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0, 32'h104,      0, 32'h0,        0, 0));
    vecs.push_back(mk("alloc",     0, 32'h100,      1, 1, 32'h100,      1, 32'h80,       0, 32'h104,     0, 32'h104,      1, 32'h80,       1, 1));
    vecs.push_back(mk("hit_wt",    0, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1, 32'h80,       0, 32'h0,        1, 1));
    vecs.push_back(mk("nt_1",      0, 32'h100,      1, 1, 32'h100,      0, 32'h80,       1, 32'h80,      1, 32'h80,       1, 32'h104,      2, 2));
    vecs.push_back(mk("nt_2",      0, 32'h100,      1, 1, 32'h100,      0, 32'h80,       0, 32'h104,     0, 32'h104,      0, 32'h0,        3, 2));
    vecs.push_back(mk("ctr_00",    0, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0, 32'h104,      0, 32'h0,        3, 2));
    vecs.push_back(mk("up_1",      0, 32'h100,      1, 1, 32'h100,      1, 32'h80,       0, 32'h104,     0, 32'h104,      1, 32'h80,       4, 3));
    vecs.push_back(mk("up_2",      0, 32'h100,      1, 1, 32'h100,      1, 32'h80,       0, 32'h104,     0, 32'h104,      1, 32'h80,       5, 4));
    vecs.push_back(mk("ctr_10",    0, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1, 32'h80,       0, 32'h0,        5, 4));
    vecs.push_back(mk("tgt_wrong", 0, 32'h100,      1, 1, 32'h100,      1, 32'h90,       1, 32'h80,      1, 32'h80,       1, 32'h90,       6, 5));
    vecs.push_back(mk("retrained", 0, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1, 32'h90,       0, 32'h0,        6, 5));
    vecs.push_back(mk("correct",   0, 32'h100,      1, 1, 32'h100,      1, 32'h90,       1, 32'h90,      1, 32'h90,       0, 32'h0,        7, 5));
    vecs.push_back(mk("non_br",    0, 32'h100,      1, 0, 32'h100,      0, 32'h0,        1, 32'h80,      1, 32'h90,       0, 32'h0,        7, 5));
    vecs.push_back(mk("not_valid", 0, 32'h100,      0, 1, 32'h100,      0, 32'h0,        1, 32'h80,      1, 32'h90,       0, 32'h0,        7, 5));
    vecs.push_back(mk("sat_11",    0, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1, 32'h90,       0, 32'h0,        7, 5));
    vecs.push_back(mk("alias",     0, 32'h100,      1, 1, 32'h200,      1, 32'h200,      0, 32'h204,     1, 32'h90,       1, 32'h200,      8, 6));
    vecs.push_back(mk("alias_miss",0, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0, 32'h104,      0, 32'h0,        8, 6));
    vecs.push_back(mk("alias_hit", 0, 32'h200,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1, 32'h200,      0, 32'h0,        8, 6));
    vecs.push_back(mk("nt_miss",   0, 32'h200,      1, 1, 32'h300,      0, 32'h0,        0, 32'h304,     1, 32'h200,      0, 32'h0,        9, 6));
    vecs.push_back(mk("kept",      0, 32'h200,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1, 32'h200,      0, 32'h0,        9, 6));
    vecs.push_back(mk("mid_rst",   1, 32'h200,      1, 1, 32'h400,      1, 32'h500,      0, 32'h404,     0, 32'h204,      0, 32'h0,        0, 0));
    vecs.push_back(mk("cleared",   0, 32'h200,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0, 32'h204,      0, 32'h0,        0, 0));
    vecs.push_back(mk("no_train",  0, 32'h400,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0, 32'h404,      0, 32'h0,        0, 0));
    vecs.push_back(mk("pc_wrap",   0, 32'hFFFF_FFFC,0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0, 32'h0,        0, 32'h0,        0, 0));
    vecs.push_back(mk("redir_wrap",0, 32'hFFFF_FFFC,1, 1, 32'hFFFF_FFFC,0, 32'h0,        1, 32'h10,      0, 32'h0,        1, 32'h0,        1, 1));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].if_pc, vecs[i].ex_valid, vecs[i].ex_is_branch,
                     vecs[i].ex_pc, vecs[i].ex_taken, vecs[i].ex_target,
                     vecs[i].ex_pred_taken, vecs[i].ex_pred_target);
      check_output({vecs[i].name, ".pred_taken"}, 32'(bp_bus.pred_taken), 32'(vecs[i].exp_pred_taken));
      check_output({vecs[i].name, ".pred_target"}, bp_bus.pred_target, vecs[i].exp_pred_target);
      check_output({vecs[i].name, ".mispredict"}, 32'(bp_bus.mispredict), 32'(vecs[i].exp_mispredict));
      if (vecs[i].exp_mispredict)
        check_output({vecs[i].name, ".redirect_pc"}, bp_bus.redirect_pc, vecs[i].exp_redirect);
      @(posedge clk);
      #1;
      check_output({vecs[i].name, ".br_count"}, bp_bus.br_count, vecs[i].exp_br);
      check_output({vecs[i].name, ".mis_count"}, bp_bus.mis_count, vecs[i].exp_mis);
    end

    // Randomized traffic against the model, starting from a clean reset.
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    model_reset();

    for (int n = 0; n < 400; n++) begin
      logic        rst, ev, eb, et, ept, xpt, xmis;
      logic [31:0] ipc, epc, etgt, eptgt, xptgt, xred;
      rst  = ($urandom_range(0, 49) == 0);
      epc  = rand_pc();
      ipc  = ($urandom_range(0, 3) == 0) ? epc : rand_pc();
      ev   = ($urandom_range(0, 3) != 0);
      eb   = ($urandom_range(0, 3) != 0);
      et   = 1'($urandom_range(0, 1));
      etgt = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 1) == 0) begin
        model_predict(epc, 1'b0, ept, eptgt);
      end else begin
        ept   = 1'($urandom_range(0, 1));
        eptgt = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      end
      apply_stimulus(rst, ipc, ev, eb, epc, et, etgt, ept, eptgt);
      model_predict(ipc, rst, xpt, xptgt);
      xmis = model_mispredict(rst, ev, eb, et, etgt, ept, eptgt);
      xred = et ? etgt : epc + 32'd4;
      check_output("rnd.pred_taken", 32'(bp_bus.pred_taken), 32'(xpt));
      check_output("rnd.pred_target", bp_bus.pred_target, xptgt);
      check_output("rnd.mispredict", 32'(bp_bus.mispredict), 32'(xmis));
      if (xmis) check_output("rnd.redirect_pc", bp_bus.redirect_pc, xred);
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else if (ev && eb) begin
        m_br = m_br + 32'd1;
        if (xmis) m_mis = m_mis + 32'd1;
        model_train(epc, et, etgt);
      end
      #1;
      check_output("rnd.br_count", bp_bus.br_count, m_br);
      check_output("rnd.mis_count", bp_bus.mis_count, m_mis);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
